// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/hazard controller: opcode constants,
// register address width and the in-flight slot record.
package alu_issue_ctrl_pkg;

    localparam int         REG_AW     = 3;
    localparam int         MAX_WB_LAT = 4;
    localparam int         SLOT_IDX_W = 2;
    localparam logic [3:0] COP_IMM    = 4'b0011;

    typedef logic [REG_AW-1:0]     reg_adr_t;
    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

    typedef struct packed {
        logic     v;
        reg_adr_t dest;
        logic     we;
    } slot_t;

    // The immediate form reuses the regB field as immediate bits.
    function automatic logic uses_src_b(input logic [3:0] cop);
        return cop != COP_IMM;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode <-> issue-controller bundle. The master is decode/fetch, the slave is
// the issue controller.
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    // Handshake: decode presents an instruction with dec_valid; it is accepted
    // (issued) in a cycle where dec_valid=1 and dec_stall=0. While dec_stall=1
    // decode must keep the same instruction and fields stable on the next cycle.
    logic        hold;
    logic        dec_valid;
    logic [3:0]  dec_cop;
    reg_adr_t    dec_regA_adr;
    reg_adr_t    dec_regB_adr;
    reg_adr_t    dec_destReg_adr;
    logic        dec_we;
    logic        dec_stall;
    logic        alu_enable;
    logic        alu_we;
    logic        fwdA_sel;
    logic        fwdB_sel;
    logic [15:0] stall_cnt;

    modport master (
        output hold, dec_valid, dec_cop, dec_regA_adr, dec_regB_adr,
               dec_destReg_adr, dec_we,
        input  dec_stall, alu_enable, alu_we, fwdA_sel, fwdB_sel, stall_cnt
    );

    modport slave (
        input  hold, dec_valid, dec_cop, dec_regA_adr, dec_regB_adr,
               dec_destReg_adr, dec_we,
        output dec_stall, alu_enable, alu_we, fwdA_sel, fwdB_sel, stall_cnt
    );

endinterface

// File: rtl/alu_issue_ctrl_inflight_slot_chain.sv
// Shift chain of in-flight register writes (slot 0 = ALU stage, last slot =
// register-file write) with a youngest-match search for two source addresses.
module alu_issue_ctrl_inflight_slot_chain
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WB_LAT = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_advance,
    input  slot_t     i_push,
    input  reg_adr_t  i_src_a,
    input  reg_adr_t  i_src_b,
    output logic      o_found_a,
    output slot_idx_t o_idx_a,
    output logic      o_found_b,
    output slot_idx_t o_idx_b
);

    slot_t r_slot [WB_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WB_LAT; i++) begin
                r_slot[i] <= '0;
            end
        end else if (i_advance) begin
            r_slot[0] <= i_push;
            for (int i = 1; i < WB_LAT; i++) begin
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        o_found_a = 1'b0;
        o_idx_a   = '0;
        o_found_b = 1'b0;
        o_idx_b   = '0;
        for (int i = WB_LAT - 1; i >= 0; i--) begin
            if (r_slot[i].v && r_slot[i].we && (r_slot[i].dest == i_src_a)) begin
                o_found_a = 1'b1;
                o_idx_a   = slot_idx_t'(i);
            end
            if (r_slot[i].v && r_slot[i].we && (r_slot[i].dest == i_src_b)) begin
                o_found_b = 1'b1;
                o_idx_b   = slot_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue and hazard controller between decode and the ALU stage: decides
// issue / forward / stall per decoded instruction and counts stall cycles.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WB_LAT = 2,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.slave   bus
);

    localparam logic FWD_ON = (FWD_EN != 0);

    logic        w_use_b;
    logic        w_found_a;
    logic        w_found_b;
    slot_idx_t   w_idx_a;
    slot_idx_t   w_idx_b;
    logic        w_fwd_a;
    logic        w_fwd_b;
    logic        w_haz_a;
    logic        w_haz_b;
    logic        w_hazard;
    logic        w_issue;
    logic        w_stall;
    slot_t       w_push;
    logic [15:0] r_stall_cnt;

    alu_issue_ctrl_inflight_slot_chain #(
        .WB_LAT (WB_LAT)
    ) u_chain (
        .clk       (clk),
        .reset     (reset),
        .i_advance (~bus.hold),
        .i_push    (w_push),
        .i_src_a   (bus.dec_regA_adr),
        .i_src_b   (bus.dec_regB_adr),
        .o_found_a (w_found_a),
        .o_idx_a   (w_idx_a),
        .o_found_b (w_found_b),
        .o_idx_b   (w_idx_b)
    );

    // Only a producer sitting in the ALU stage can be bypassed; anything older
    // must wait, including the slot writing the register file this cycle.
    assign w_use_b  = uses_src_b(bus.dec_cop);
    assign w_fwd_a  = FWD_ON & w_found_a & (w_idx_a == '0);
    assign w_fwd_b  = FWD_ON & w_use_b & w_found_b & (w_idx_b == '0);
    assign w_haz_a  = w_found_a & ~w_fwd_a;
    assign w_haz_b  = w_use_b & w_found_b & ~w_fwd_b;
    assign w_hazard = w_haz_a | w_haz_b;

    assign w_issue  = bus.dec_valid & ~w_hazard & ~bus.hold;
    assign w_stall  = bus.dec_valid & (w_hazard | bus.hold);
    assign w_push   = w_issue ? '{v: 1'b1, dest: bus.dec_destReg_adr, we: bus.dec_we}
                              : '0;

    assign bus.dec_stall  = w_stall;
    assign bus.alu_enable = ~bus.hold;
    assign bus.alu_we     = bus.dec_we & w_issue;
    assign bus.fwdA_sel   = bus.dec_valid & w_fwd_a;
    assign bus.fwdB_sel   = bus.dec_valid & w_fwd_b;
    assign bus.stall_cnt  = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: four parameter variants share one stimulus stream
// and are compared every cycle against an age-list reference model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int N_DUT = 4;

  function automatic int lat_of(input int g);
    case (g)
      0: return 2;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int fwd_of(input int g);
    case (g)
      0: return 1;
      1: return 0;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  // clock / reset
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       t_hold, t_valid, t_we;
  logic [3:0] t_cop;
  logic [2:0] t_ra, t_rb, t_rd;

  logic        o_stall [N_DUT];
  logic        o_en    [N_DUT];
  logic        o_we    [N_DUT];
  logic        o_fa    [N_DUT];
  logic        o_fb    [N_DUT];
  logic [15:0] o_cnt   [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    alu_issue_ctrl_if bus_g ();
    assign bus_g.hold            = t_hold;
    assign bus_g.dec_valid       = t_valid;
    assign bus_g.dec_cop         = t_cop;
    assign bus_g.dec_regA_adr    = t_ra;
    assign bus_g.dec_regB_adr    = t_rb;
    assign bus_g.dec_destReg_adr = t_rd;
    assign bus_g.dec_we          = t_we;
    assign o_stall[g] = bus_g.dec_stall;
    assign o_en[g]    = bus_g.alu_enable;
    assign o_we[g]    = bus_g.alu_we;
    assign o_fa[g]    = bus_g.fwdA_sel;
    assign o_fb[g]    = bus_g.fwdB_sel;
    assign o_cnt[g]   = bus_g.stall_cnt;
    alu_issue_ctrl #(.WB_LAT(lat_of(g)), .FWD_EN(fwd_of(g))) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_g.slave)
    );
  end

  // reference model: list of pending writes tagged with cycles since issue
  typedef struct { logic [2:0] dest; int age; } ent_t;
  typedef struct packed { logic stall, en, we, fa, fb; } exp_t;
  ent_t fl [N_DUT][$];
  int   m_cnt [N_DUT];

  int n_vec = 0;
  int n_bad = 0;

  function automatic int youngest(input int k, input logic [2:0] src);
    int best = 0;
    for (int j = 0; j < fl[k].size(); j++) begin
      if (fl[k][j].dest == src && (best == 0 || fl[k][j].age < best)) best = fl[k][j].age;
    end
    return best;
  endfunction

  function automatic exp_t predict(input int k);
    exp_t e;
    int ya, yb;
    logic fa, fb, haz;
    ya  = youngest(k, t_ra);
    yb  = (t_cop != COP_IMM) ? youngest(k, t_rb) : 0;
    fa  = (ya == 1) && (fwd_of(k) != 0);
    fb  = (yb == 1) && (fwd_of(k) != 0);
    haz = (ya != 0 && !fa) || (yb != 0 && !fb);
    e.stall = t_valid && (haz || t_hold);
    e.en    = !t_hold;
    e.we    = t_we && t_valid && !haz && !t_hold;
    e.fa    = t_valid && fa;
    e.fb    = t_valid && fb;
    return e;
  endfunction

  task automatic model_edge(input int k, input exp_t e);
    ent_t nq[$];
    ent_t x;
    if (reset) begin
      fl[k].delete();
      m_cnt[k] = 0;
      return;
    end
    if (e.stall && m_cnt[k] < 65535) m_cnt[k]++;
    if (!t_hold) begin
      for (int j = 0; j < fl[k].size(); j++) begin
        x = fl[k][j];
        x.age++;
        if (x.age <= lat_of(k)) nq.push_back(x);
      end
      if (e.we) begin
        x.dest = t_rd;
        x.age  = 1;
        nq.push_back(x);
      end
      fl[k] = nq;
    end
  endtask

  // scoreboard
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s dut%0d (lat=%0d fwd=%0d): got %0h expected %0h",
               name, k, lat_of(k), fwd_of(k), act, expv);
    end
  endtask

  // driver tasks
  task automatic drive(input logic h, input logic v, input logic [3:0] cop,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                       input logic we, input logic rst);
    t_hold = h; t_valid = v; t_cop = cop; t_ra = ra; t_rb = rb; t_rd = rd; t_we = we;
    reset = rst;
    @(negedge clk);
  endtask

  task automatic commit();
    exp_t e [N_DUT];
    for (int k = 0; k < N_DUT; k++) begin
      e[k] = predict(k);
      chk("m_stall", k, o_stall[k], e[k].stall);
      chk("m_en",    k, o_en[k],    e[k].en);
      chk("m_we",    k, o_we[k],    e[k].we);
      chk("m_fwdA",  k, o_fa[k],    e[k].fa);
      chk("m_fwdB",  k, o_fb[k],    e[k].fb);
      chk("m_cnt",   k, o_cnt[k],   m_cnt[k]);
    end
    @(posedge clk);
    for (int k = 0; k < N_DUT; k++) model_edge(k, e[k]);
    #1;
  endtask

  task automatic step(input logic h, input logic v, input logic [3:0] cop,
                      input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                      input logic we, input logic rst);
    drive(h, v, cop, ra, rb, rd, we, rst);
    commit();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic h, v; logic [3:0] cop; logic [2:0] ra, rb, rd; logic we;
    logic x_stall, x_en, x_we, x_fa, x_fb;
  } vec_t;
  vec_t tbl [13];

  initial begin
    // vectors for the lat=2 forwarding variant (dut0), applied from reset
    tbl[0]  = '{1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'd0, 3'd1, 3'd1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'd0, 3'd1, 3'd1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'd3, 3'd0, 3'd6, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'd0, 3'd7, 3'd6, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'd0, 3'd7, 3'd6, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'd0, 3'd7, 3'd6, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'd0, 3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'd0, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'd0, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < N_DUT; k++) m_cnt[k] = 0;
    t_hold = 1'b0; t_valid = 1'b0; t_cop = 4'd0; t_ra = 3'd0; t_rb = 3'd0; t_rd = 3'd0;
    t_we = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset state
    drive(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < N_DUT; k++) begin
      chk("rst_stall", k, o_stall[k], 1'b0);
      chk("rst_en",    k, o_en[k],    1'b1);
      chk("rst_we",    k, o_we[k],    1'b0);
      chk("rst_fwd",   k, {o_fa[k], o_fb[k]}, 2'b00);
      chk("rst_cnt",   k, o_cnt[k],   16'd0);
    end
    commit();

    // table-driven vectors
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].cop, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].we, 1'b0);
      chk($sformatf("tbl%0d_stall", i), 0, o_stall[0], tbl[i].x_stall);
      chk($sformatf("tbl%0d_en", i),    0, o_en[0],    tbl[i].x_en);
      chk($sformatf("tbl%0d_we", i),    0, o_we[0],    tbl[i].x_we);
      chk($sformatf("tbl%0d_fwdA", i),  0, o_fa[0],    tbl[i].x_fa);
      chk($sformatf("tbl%0d_fwdB", i),  0, o_fb[0],    tbl[i].x_fb);
      commit();
    end
    drive(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("tbl_cnt", 0, o_cnt[0], 16'd4);
    commit();

    // back-to-back dependent pair, with and without forwarding
    do_reset();
    drive(1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0);
    chk("pair_p_we", 1, o_we[1], 1'b1);
    commit();
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
    chk("pair_fwd_fa", 0, o_fa[0], 1'b1);
    chk("pair_fwd_stall", 0, o_stall[0], 1'b0);
    chk("pair_fwd_we", 0, o_we[0], 1'b1);
    chk("pair_nofwd_s1", 1, {o_stall[1], o_we[1]}, 2'b10);
    commit();
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
    chk("pair_nofwd_s2", 1, {o_stall[1], o_we[1]}, 2'b10);
    commit();
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
    chk("pair_nofwd_iss", 1, {o_stall[1], o_we[1]}, 2'b01);
    commit();
    drive(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("pair_nofwd_cnt", 1, o_cnt[1], 16'd2);
    commit();

    // reader two behind its producer: writeback slot hit is a stall, not a forward
    do_reset();
    step(1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd6, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
    chk("gap_stall", 0, {o_stall[0], o_fa[0]}, 2'b10);
    commit();
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
    chk("gap_issue", 0, {o_stall[0], o_we[0]}, 2'b01);
    commit();

    // immediate form ignores regB; register form honours it
    do_reset();
    step(1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, COP_IMM, 3'd2, 3'd1, 3'd4, 1'b1, 1'b0);
    chk("imm_fwd", 0, {o_stall[0], o_fb[0]}, 2'b00);
    chk("imm_nofwd", 1, {o_stall[1], o_fb[1]}, 2'b00);
    commit();
    do_reset();
    step(1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'd0, 3'd2, 3'd1, 3'd4, 1'b1, 1'b0);
    chk("reg_fwd", 0, {o_stall[0], o_fb[0]}, 2'b01);
    chk("reg_nofwd", 1, {o_stall[1], o_fb[1]}, 2'b10);
    commit();

    // hold freezes the chain; the entry resumes afterwards
    do_reset();
    step(1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
      chk("hold_ctl", 0, {o_en[0], o_stall[0], o_we[0]}, 3'b010);
      commit();
    end
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
    chk("hold_resume", 0, {o_stall[0], o_fa[0], o_we[0]}, 3'b011);
    chk("hold_cnt", 0, o_cnt[0], 16'd3);
    chk("hold_lat4", 3, o_stall[3], 1'b1);
    commit();

    // saturation, then reset in the middle of a stall
    do_reset();
    t_hold = 1'b1; t_valid = 1'b1; t_cop = 4'd0; t_ra = 3'd0; t_rb = 3'd0; t_rd = 3'd0;
    t_we = 1'b1; reset = 1'b0;
    repeat (65534) @(posedge clk);
    for (int k = 0; k < N_DUT; k++) m_cnt[k] = 65534;
    #1;
    drive(1'b1, 1'b1, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    chk("sat_fffe", 0, o_cnt[0], 16'hFFFE);
    commit();
    step(1'b1, 1'b1, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0);
    chk("sat_ffff", 0, o_cnt[0], 16'hFFFF);
    commit();
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b1);
    chk("midrst_stalling", 1, o_stall[1], 1'b1);
    commit();
    drive(1'b0, 1'b1, 4'd0, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
    for (int k = 0; k < N_DUT; k++) begin
      chk("midrst_issue", k, {o_stall[k], o_we[k], o_fa[k]}, 3'b010);
      chk("midrst_cnt", k, o_cnt[k], 16'd0);
    end
    commit();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) == 0) ? COP_IMM : 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           ($urandom_range(0, 5) != 0), ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
